// File: rtl/rmio_rf_sequencer.sv
// -----------------------------------------------------------------------------
// rmio_rf_sequencer
//
// RF-side driver of the RF-RAM / execute-unit operand link. For each accepted
// command it reads INPUT_NUM operand rows from the register-file RAM and hands
// them to the EU one row per cycle with a one-hot write strobe. It then waits
// EU_LAT cycles, pulls OUTPUT_NUM result rows back with a one-hot read strobe,
// and writes each one into the RAM in the following cycle.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready command handshake; ready only while idle
//   i_cmd_src_base          first operand row address (sampled on accept)
//   i_cmd_dst_base          first result row address (sampled on accept)
//   o_done                  one-cycle pulse when a command completes
//   o_ram_re/o_ram_raddr    RAM read port; i_ram_rdata valid one cycle later
//   o_ram_we/o_ram_waddr/
//   o_ram_wdata             RAM write port
//   o_rmio_input_data       operand row to the EU (zero when no strobe)
//   o_rmio_input_we         one-hot operand slot strobe
//   o_rmio_output_re        one-hot result slot strobe
//   i_rmio_output_data      EU result row, valid while its strobe is high
// -----------------------------------------------------------------------------
module rmio_rf_sequencer #(
    parameter int INPUT_NUM  = 1,
    parameter int OUTPUT_NUM = 1,
    parameter int DATA_W     = 1408,
    parameter int ADDR_W     = 8,
    parameter int EU_LAT     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_W-1:0]     i_cmd_src_base,
    input  logic [ADDR_W-1:0]     i_cmd_dst_base,
    output logic                  o_done,
    output logic                  o_ram_re,
    output logic [ADDR_W-1:0]     o_ram_raddr,
    input  logic [DATA_W-1:0]     i_ram_rdata,
    output logic                  o_ram_we,
    output logic [ADDR_W-1:0]     o_ram_waddr,
    output logic [DATA_W-1:0]     o_ram_wdata,
    output logic [DATA_W-1:0]     o_rmio_input_data,
    output logic [0:INPUT_NUM-1]  o_rmio_input_we,
    output logic [0:OUTPUT_NUM-1] o_rmio_output_re,
    input  logic [DATA_W-1:0]     i_rmio_output_data
);

    localparam int IW = (INPUT_NUM  > 1) ? $clog2(INPUT_NUM)  : 1;
    localparam int OW = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1;
    localparam int WW = (EU_LAT     > 0) ? $clog2(EU_LAT + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_W-1:0]     r_dst_base;
    logic [IW-1:0]         r_rd_idx;
    logic [OW-1:0]         r_out_idx;
    logic [WW-1:0]         r_wait;
    logic                  r_done;
    logic                  r_ram_re;
    logic [ADDR_W-1:0]     r_ram_raddr;
    logic                  r_ram_we;
    logic [ADDR_W-1:0]     r_ram_waddr;
    logic [DATA_W-1:0]     r_ram_wdata;
    logic [0:INPUT_NUM-1]  r_in_we;
    logic [0:OUTPUT_NUM-1] r_out_re;

    logic [0:INPUT_NUM-1]  w_in_hot;     // one-hot of the read being issued now
    logic [0:OUTPUT_NUM-1] w_out_first;  // strobe pattern for result slot 0
    logic                  w_rd_last;
    logic                  w_out_last;
    logic                  w_wait_over;

    // The operand strobe for read i is raised in the cycle after the read is
    // issued, i.e. when the RAM data for row i arrives.
    for (genvar gi = 0; gi < INPUT_NUM; gi++) begin : g_in_hot
        assign w_in_hot[gi] = (r_rd_idx == IW'(gi));
    end

    for (genvar gi = 0; gi < OUTPUT_NUM; gi++) begin : g_out_first
        assign w_out_first[gi] = (gi == 0);
    end

    assign w_rd_last   = (r_rd_idx  == IW'(INPUT_NUM - 1));
    assign w_out_last  = (r_out_idx == OW'(OUTPUT_NUM - 1));
    // WAIT is entered in the cycle of the last operand strobe; after EU_LAT
    // further cycles the first result strobe is launched.
    assign w_wait_over = (r_wait == WW'(EU_LAT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_dst_base  <= '0;
            r_rd_idx    <= '0;
            r_out_idx   <= '0;
            r_wait      <= '0;
            r_done      <= 1'b0;
            r_ram_re    <= 1'b0;
            r_ram_raddr <= '0;
            r_ram_we    <= 1'b0;
            r_ram_waddr <= '0;
            r_ram_wdata <= '0;
            r_in_we     <= '0;
            r_out_re    <= '0;
        end else begin
            r_in_we <= '0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_dst_base  <= i_cmd_dst_base;
                        r_ram_raddr <= i_cmd_src_base;
                        r_ram_re    <= 1'b1;
                        r_rd_idx    <= '0;
                        r_out_idx   <= '0;
                        r_wait      <= '0;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    r_in_we <= w_in_hot;
                    if (w_rd_last) begin
                        r_ram_re <= 1'b0;
                        r_state  <= S_WAIT;
                    end else begin
                        r_rd_idx    <= r_rd_idx + IW'(1);
                        r_ram_raddr <= r_ram_raddr + ADDR_W'(1);
                    end
                end
                S_WAIT: begin
                    if (w_wait_over) begin
                        r_out_re <= w_out_first;
                        r_state  <= S_DRAIN;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_DRAIN: begin
                    // Capture the EU row while its strobe is high and write
                    // it back to the RAM in the next cycle.
                    r_ram_we    <= 1'b1;
                    r_ram_waddr <= r_dst_base + ADDR_W'(r_out_idx);
                    r_ram_wdata <= i_rmio_output_data;
                    if (w_out_last) begin
                        r_out_re <= '0;
                        r_state  <= S_FLUSH;
                    end else begin
                        r_out_idx <= r_out_idx + OW'(1);
                        r_out_re  <= r_out_re >> 1;
                    end
                end
                S_FLUSH: begin
                    r_ram_we <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready       = (r_state == S_IDLE);
    assign o_done            = r_done;
    assign o_ram_re          = r_ram_re;
    assign o_ram_raddr       = r_ram_raddr;
    assign o_ram_we          = r_ram_we;
    assign o_ram_waddr       = r_ram_waddr;
    assign o_ram_wdata       = r_ram_wdata;
    assign o_rmio_input_we   = r_in_we;
    assign o_rmio_output_re  = r_out_re;
    // Operand bus is forced to zero outside strobe cycles.
    assign o_rmio_input_data = (|r_in_we) ? i_ram_rdata : '0;

endmodule

// File: tb/tb_rmio_rf_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rmio_rf_sequencer
//
// Four instances with different INPUT_NUM/OUTPUT_NUM/EU_LAT builds, each with
// its own RAM and EU model. A table of commands selects the build, bases,
// whether cmd_valid is held high through the command, and an optional reset
// abort cycle. Every cycle of every command is compared against the expected
// cycle schedule; random back-to-back commands follow the table.
// -----------------------------------------------------------------------------
module tb_rmio_rf_sequencer;

    localparam int DW   = 1408;
    localparam int NCFG = 4;
    localparam int CN [NCFG] = '{1, 3, 2, 1};
    localparam int CM [NCFG] = '{1, 2, 2, 2};
    localparam int CL [NCFG] = '{2, 0, 1, 2};
    localparam int NV = 10;

    typedef struct {
        int         cfg;
        logic [7:0] src;
        logic [7:0] dst;
        bit         hold;
        int         abort_k;
    } vec_t;

    vec_t tbl [NV];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_err   = 0;
    int fin_cnt = 0;

    function automatic logic [DW-1:0] pat(input int a);
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++)
            r[w*32 +: 32] = (32'(a) * 32'h9E3779B9) ^ (32'(w) * 32'h85EBCA6B) ^ 32'h1234_5678;
        return r;
    endfunction

    initial begin
        tbl[0] = '{0, 8'h10, 8'h20, 1'b0, 0};
        tbl[1] = '{0, 8'h30, 8'h40, 1'b1, 0};   // cmd_valid held with junk fields
        tbl[2] = '{0, 8'h31, 8'h41, 1'b0, 0};   // accepted right after the busy one
        tbl[3] = '{0, 8'hFF, 8'h00, 1'b0, 0};
        tbl[4] = '{1, 8'h05, 8'h80, 1'b0, 0};
        tbl[5] = '{1, 8'hFE, 8'hFF, 1'b0, 0};
        tbl[6] = '{2, 8'hFF, 8'hFF, 1'b0, 0};   // both bases wrap
        tbl[7] = '{2, 8'h00, 8'h01, 1'b0, 0};
        tbl[8] = '{3, 8'h50, 8'h60, 1'b0, 5};   // reset during first DRAIN cycle
        tbl[9] = '{3, 8'h50, 8'h60, 1'b0, 0};
    end

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int N = CN[gi];
        localparam int M = CM[gi];
        localparam int L = CL[gi];

        logic          rst_n;
        logic          cmd_valid, cmd_ready, done, ram_re, ram_we;
        logic [7:0]    cmd_src, cmd_dst, raddr, waddr;
        logic [DW-1:0] rdata, wdata, in_data, eu_data;
        logic [0:N-1]  in_we;
        logic [0:M-1]  out_re;
        logic [DW-1:0] mem  [256];
        logic [DW-1:0] gmem [256];
        logic [DW-1:0] eu_op [N];

        rmio_rf_sequencer #(
            .INPUT_NUM (N),
            .OUTPUT_NUM(M),
            .DATA_W    (DW),
            .ADDR_W    (8),
            .EU_LAT    (L)
        ) u_dut (
            .i_clk             (clk),
            .i_rst_n           (rst_n),
            .i_cmd_valid       (cmd_valid),
            .o_cmd_ready       (cmd_ready),
            .i_cmd_src_base    (cmd_src),
            .i_cmd_dst_base    (cmd_dst),
            .o_done            (done),
            .o_ram_re          (ram_re),
            .o_ram_raddr       (raddr),
            .i_ram_rdata       (rdata),
            .o_ram_we          (ram_we),
            .o_ram_waddr       (waddr),
            .o_ram_wdata       (wdata),
            .o_rmio_input_data (in_data),
            .o_rmio_input_we   (in_we),
            .o_rmio_output_re  (out_re),
            .i_rmio_output_data(eu_data)
        );

        // RAM model: one-cycle registered read, write on ram_we.
        initial begin
            for (int a = 0; a < 256; a++) mem[a] = pat(a + gi * 256);
            rdata = '0;
            forever begin
                @(posedge clk);
                if (ram_we) mem[waddr] <= wdata;
                if (ram_re) rdata <= mem[raddr];
            end
        end

        // EU model: latches delivered operands, returns ~op[j%N] ^ (j+1).
        always @(posedge clk)
            for (int i = 0; i < N; i++)
                if (in_we[i]) eu_op[i] <= in_data;

        always_comb begin
            eu_data = {(DW / 32){32'hBADC0DE5}};
            for (int j = 0; j < M; j++)
                if (out_re[j]) eu_data = ~eu_op[j % N] ^ DW'(j + 1);
        end

        task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL cfg%0d %s cycle %0d: got %0h expected %0h", gi, nm, k, act, exp);
            end
        endtask

        task automatic chk_d(input string nm, input int k, input logic [DW-1:0] act, input logic [DW-1:0] exp);
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL cfg%0d %s cycle %0d: got ..%h expected ..%h (low 64 bits)",
                         gi, nm, k, act[63:0], exp[63:0]);
            end
        endtask

        task automatic chk_reset(input int k);
            chk("rst_cmd_ready", k, 64'(cmd_ready), 64'd1);
            chk("rst_done",      k, 64'(done),      64'd0);
            chk("rst_ram_re",    k, 64'(ram_re),    64'd0);
            chk("rst_ram_we",    k, 64'(ram_we),    64'd0);
            chk("rst_raddr",     k, 64'(raddr),     64'd0);
            chk("rst_waddr",     k, 64'(waddr),     64'd0);
            chk("rst_in_we",     k, 64'(in_we),     64'd0);
            chk("rst_out_re",    k, 64'(out_re),    64'd0);
            chk_d("rst_wdata",   k, wdata,   '0);
            chk_d("rst_in_data", k, in_data, '0);
        endtask

        // Called at a falling edge that belongs to the acceptance cycle (0).
        // Returns at the falling edge of cycle T+1, the first idle cycle.
        task automatic run_cmd(input logic [7:0] src, input logic [7:0] dst,
                               input bit hold, input int abort_k);
            logic [0:N-1]  e_in;
            logic [0:M-1]  e_out;
            logic [DW-1:0] e_op [N];
            int            T;
            int            j;
            T = N + M + L + 3;
            chk("cmd_ready_accept", 0, 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b1;
            cmd_src   = src;
            cmd_dst   = dst;
            for (int k = 1; k <= T + 1; k++) begin
                @(negedge clk);
                chk("cmd_ready", k, 64'(cmd_ready), 64'(k == T + 1));
                chk("done",      k, 64'(done),      64'(k == T));
                chk("ram_re",    k, 64'(ram_re),    64'(k >= 1 && k <= N));
                chk("re_we_excl", k, 64'(ram_re & ram_we), 64'd0);
                if (k <= N)
                    chk("ram_raddr", k, 64'(raddr), 64'(8'(src + k - 1)));
                e_in = '0;
                if (k >= 2 && k <= N + 1) e_in[k-2] = 1'b1;
                chk("input_we", k, 64'(in_we), 64'(e_in));
                if (k >= 2 && k <= N + 1) begin
                    e_op[k-2] = gmem[8'(src + k - 2)];
                    chk_d("input_data", k, in_data, e_op[k-2]);
                end else begin
                    chk_d("input_data_idle", k, in_data, '0);
                end
                e_out = '0;
                j = k - (N + 2 + L);
                if (j >= 0 && j < M) e_out[j] = 1'b1;
                chk("output_re", k, 64'(out_re), 64'(e_out));
                j = k - (N + 3 + L);
                chk("ram_we", k, 64'(ram_we), 64'(j >= 0 && j < M));
                if (j >= 0 && j < M) begin
                    chk("ram_waddr", k, 64'(waddr), 64'(8'(dst + j)));
                    chk_d("ram_wdata", k, wdata, ~e_op[j % N] ^ DW'(j + 1));
                    gmem[8'(dst + j)] = ~e_op[j % N] ^ DW'(j + 1);
                end
                if (k == abort_k) begin
                    rst_n     = 1'b0;
                    cmd_valid = 1'b0;
                    #1;
                    chk_reset(k);
                    @(negedge clk);
                    rst_n = 1'b1;
                    for (int c = 1; c <= 6; c++) begin
                        @(negedge clk);
                        chk("abort_ram_we",    k + c, 64'(ram_we),    64'd0);
                        chk("abort_done",      k + c, 64'(done),      64'd0);
                        chk("abort_cmd_ready", k + c, 64'(cmd_ready), 64'd1);
                    end
                    return;
                end
                if (hold) begin
                    cmd_src = 8'($urandom);
                    cmd_dst = 8'($urandom);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        endtask

        initial begin
            rst_n     = 1'b0;
            cmd_valid = 1'b0;
            cmd_src   = '0;
            cmd_dst   = '0;
            for (int a = 0; a < 256; a++) gmem[a] = pat(a + gi * 256);
            repeat (2) @(negedge clk);
            chk_reset(0);
            rst_n = 1'b1;
            @(negedge clk);
            for (int t = 0; t < NV; t++)
                if (tbl[t].cfg == gi)
                    run_cmd(tbl[t].src, tbl[t].dst, tbl[t].hold, tbl[t].abort_k);
            for (int r = 0; r < 6; r++)
                run_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 0);
            cmd_valid = 1'b0;
            fin_cnt++;
        end
    end

    initial begin
        for (int c = 0; c < 20000 && fin_cnt < NCFG; c++) @(posedge clk);
        if (fin_cnt < NCFG) begin
            n_err++;
            $display("FAIL timeout: got %0d finished instances expected %0d", fin_cnt, NCFG);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rmio_rf_sequencer.md
# rmio_rf_sequencer

RF-side driver of the RF-RAM/execute-unit operand link: for each accepted command it reads `INPUT_NUM` operand rows from the register-file RAM and delivers them to the execute unit (EU), one row per cycle with a one-hot write strobe. It then waits a fixed EU latency, pulls `OUTPUT_NUM` result rows back with a one-hot read strobe and writes them into the RAM. It sits between the RF RAM macro and the EU and owns the `rf` end of the link.

## Interface
- `INPUT_NUM`, 1: operand rows per command (≥1).
- `OUTPUT_NUM`, 1: result rows per command (≥1).
- `DATA_W`, 1408: row width in bits (176 bytes).
- `ADDR_W`, 8: RF RAM address width.
- `EU_LAT`, 2: cycles from the last `rmio_input_we` to the first `rmio_output_re` (≥0).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_src_base` in ADDR_W: first operand row address.
- `cmd_dst_base` in ADDR_W: first result row address.
- `done` out 1: one-cycle pulse when a command completes.
- `ram_re` out 1: RAM read enable.
- `ram_raddr` out ADDR_W: RAM read address.
- `ram_rdata` in DATA_W: RAM read data, valid 1 cycle after `ram_re`.
- `ram_we` out 1: RAM write enable.
- `ram_waddr` out ADDR_W: RAM write address.
- `ram_wdata` out DATA_W: RAM write data.
- `rmio_input_data` out DATA_W: operand row to the EU.
- `rmio_input_we` out [0:INPUT_NUM-1]: one-hot operand slot strobe.
- `rmio_output_re` out [0:OUTPUT_NUM-1]: one-hot result slot strobe.
- `rmio_output_data` in DATA_W: EU result row, valid combinationally in the cycle its `rmio_output_re` bit is high.

## Operation
- States: IDLE, READ, WAIT, DRAIN, FLUSH, DONE.
- IDLE: `cmd_ready`=1. When `cmd_valid` is high, latch both bases, clear the counters and go to READ.
- READ: issue `ram_re` with `ram_raddr`=`src_base`+i, for i=0..INPUT_NUM-1, one row per cycle. Go to WAIT after the last issue.
- Operand delivery:
  - Runs one cycle behind each read and overlaps the next read.
  - `rmio_input_data`=`ram_rdata` and `rmio_input_we[i]`=1, all other bits 0.
  - `rmio_input_data` is 0 whenever no `rmio_input_we` bit is set.
- WAIT: counts EU_LAT cycles after the cycle of the last `rmio_input_we`. If EU_LAT=0, DRAIN directly follows the last `rmio_input_we` cycle.
- DRAIN: assert `rmio_output_re[j]` for j=0..OUTPUT_NUM-1, one cycle each. Register `rmio_output_data` at the end of each such cycle.
- Result write: in the following cycle, `ram_we`=1, `ram_waddr`=`dst_base`+j and `ram_wdata`=the registered row.
- FLUSH: one cycle that covers the final `ram_we`.
- DONE: `done`=1 for one cycle, then IDLE. `cmd_ready`=1 again from the cycle after `done`.
- Addresses add modulo 2^ADDR_W, so base+offset wraps past the top row to 0.
- `cmd_valid` is ignored outside IDLE. Command fields are sampled only on acceptance.
- `ram_re` and `ram_we` are never high in the same cycle.
- At most one strobe bit is set in `rmio_input_we` and in `rmio_output_re` in any cycle.

## Timing
- Cycle 0 is the acceptance cycle (`cmd_valid` & `cmd_ready`). With N=INPUT_NUM, M=OUTPUT_NUM, L=EU_LAT:
  - `ram_re`: cycles 1..N.
  - `rmio_input_we`: cycles 2..N+1.
  - WAIT: cycles N+2..N+1+L.
  - `rmio_output_re`: cycles N+2+L..N+1+L+M.
  - `ram_we`: cycles N+3+L..N+2+L+M.
  - `done`: cycle N+3+L+M.
- Latency from acceptance to `done` is N+M+L+3 cycles.
- Reset values: `cmd_ready`=1. `done`, `ram_re`, `ram_we`, `rmio_input_we` and `rmio_output_re` = 0. `ram_raddr`, `ram_waddr`, `ram_wdata` and `rmio_input_data` = 0.
- Reset mid-command: all outputs return to reset values asynchronously. The command is dropped: no further `ram_we`, no `done`.
- All outputs are registered except `cmd_ready`, which decodes IDLE, and `rmio_input_data`, which is `ram_rdata` gated by the strobe.

## Test plan
- N=1, M=1, L=2, src=0x10, dst=0x20:
  - `ram_re` at cycle 1 with addr 0x10.
  - `rmio_input_we`=1 at cycle 2 with `rmio_input_data` equal to RAM[0x10].
  - `rmio_output_re` at cycle 5.
  - `ram_we` at cycle 6 with addr 0x20 and the EU data of cycle 5.
  - `done` at cycle 7.
- N=3, M=2, L=0:
  - `rmio_input_we` walks 100→010→001 on cycles 2–4.
  - `rmio_output_re` 10→01 on cycles 5–6.
  - writes to dst and dst+1 on cycles 6–7.
  - `done` at cycle 8.
- Wrap, N=2, M=2, src=0xFF, dst=0xFF, ADDR_W=8:
  - reads 0xFF then 0x00.
  - writes 0xFF then 0x00.
- Busy rejection: hold `cmd_valid` high continuously with changing fields.
  - Only the first command runs.
  - The second is accepted in the cycle after `done` with the fields present then.
- Reset abort: assert `rst_n`=0 during DRAIN of an N=1, M=2 command.
  - All outputs go to 0 immediately, `cmd_ready`=1.
  - No `ram_we` and no `done` occur after release.
- Back-to-back commands with randomized N/M/L builds against a RAM/EU model:
  - every result row lands at dst+j and matches the model.
  - the one-hot and no-overlap rules hold in every cycle.
